// File: rtl/vx_mem_responder.sv
// vx_mem_responder: single-port line-addressed memory model with byte-enable
// writes, a fixed-latency read pipeline and a credit-limited response FIFO.
// Read responses bypass the FIFO when it is empty so the nominal read latency
// is exactly LATENCY cycles.
module vx_mem_responder #(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int MEM_DATA_SIZE  = 16,
  parameter int MEM_TAG_WIDTH  = 8,
  parameter int NUM_LINES      = 256,
  parameter int LATENCY        = 2,
  parameter int RSP_QUEUE_SIZE = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mem_req_valid,
  input  logic                          mem_req_rw,
  input  logic [MEM_ADDR_WIDTH-1:0]     mem_req_addr,
  input  logic [MEM_DATA_SIZE-1:0]      mem_req_byteen,
  input  logic [MEM_DATA_SIZE*8-1:0]    mem_req_data,
  input  logic [MEM_TAG_WIDTH-1:0]      mem_req_tag,
  output logic                          mem_req_ready,
  output logic                          mem_rsp_valid,
  output logic [MEM_DATA_SIZE*8-1:0]    mem_rsp_data,
  output logic [MEM_TAG_WIDTH-1:0]      mem_rsp_tag,
  input  logic                          mem_rsp_ready
);

  localparam int MEM_DATA_WIDTH = MEM_DATA_SIZE * 8;
  localparam int LINE_SEL       = $clog2(NUM_LINES);
  localparam int PW             = $clog2(RSP_QUEUE_SIZE) + 1;
  localparam int AW             = (RSP_QUEUE_SIZE > 1) ? $clog2(RSP_QUEUE_SIZE) : 1;

  localparam logic [PW-1:0] QDEPTH   = PW'(RSP_QUEUE_SIZE);
  localparam logic [PW-1:0] ONE_P    = PW'(1);
  localparam logic [AW-1:0] LAST_PTR = AW'(RSP_QUEUE_SIZE - 1);
  localparam logic [AW-1:0] ONE_A    = AW'(1);

  // Circular pointer advance over a queue that need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + ONE_A;
  endfunction

  // Backing store: zero from time 0, never touched by reset.
  logic [MEM_DATA_WIDTH-1:0] mem_q [NUM_LINES] = '{default: '0};

  logic [LINE_SEL-1:0] line_idx;
  logic                req_fire, rd_fire, wr_fire, rsp_fire;
  logic                unused_addr;

  logic [PW-1:0] pending_q, pending_d;

  logic                      pipe_vld_q  [LATENCY];
  logic                      pipe_vld_d  [LATENCY];
  logic [MEM_DATA_WIDTH-1:0] pipe_data_q [LATENCY];
  logic [MEM_DATA_WIDTH-1:0] pipe_data_d [LATENCY];
  logic [MEM_TAG_WIDTH-1:0]  pipe_tag_q  [LATENCY];
  logic [MEM_TAG_WIDTH-1:0]  pipe_tag_d  [LATENCY];
  logic                      pipe_out_vld;

  logic [MEM_DATA_WIDTH-1:0] fifo_data_q [RSP_QUEUE_SIZE];
  logic [MEM_TAG_WIDTH-1:0]  fifo_tag_q  [RSP_QUEUE_SIZE];
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]             fifo_cnt_q, fifo_cnt_d;
  logic                      fifo_empty, fifo_full, fifo_enq, fifo_deq;

  // Upper address bits select nothing; the store aliases every NUM_LINES lines.
  assign line_idx    = mem_req_addr[LINE_SEL-1:0];
  assign unused_addr = &{1'b0, mem_req_addr};

  // Request/response handshakes; requests are ignored while reset is high.
  always_comb begin
    mem_req_ready = (pending_q < QDEPTH);
    req_fire      = mem_req_valid && mem_req_ready && !reset;
    rd_fire       = req_fire && !mem_req_rw;
    wr_fire       = req_fire && mem_req_rw;

    fifo_empty    = (fifo_cnt_q == '0);
    fifo_full     = (fifo_cnt_q == QDEPTH);
    pipe_out_vld  = pipe_vld_q[LATENCY-1];

    // Empty FIFO falls through to the pipeline output.
    mem_rsp_valid = fifo_empty ? pipe_out_vld            : 1'b1;
    mem_rsp_data  = fifo_empty ? pipe_data_q[LATENCY-1]  : fifo_data_q[rd_ptr_q];
    mem_rsp_tag   = fifo_empty ? pipe_tag_q[LATENCY-1]   : fifo_tag_q[rd_ptr_q];
    rsp_fire      = mem_rsp_valid && mem_rsp_ready;

    fifo_deq      = !fifo_empty && mem_rsp_ready;
    // A pipeline output consumed directly through the bypass is not stored.
    fifo_enq      = pipe_out_vld && !(fifo_empty && mem_rsp_ready);
  end

  // Byte-masked line write.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < MEM_DATA_SIZE; b++) begin
        if (mem_req_byteen[b]) begin
          mem_q[line_idx][b*8 +: 8] <= mem_req_data[b*8 +: 8];
        end
      end
    end
  end

  // Next-state for the outstanding-read credit counter.
  always_comb begin
    pending_d = pending_q;
    if (rd_fire && !rsp_fire) begin
      pending_d = pending_q + ONE_P;
    end else if (!rd_fire && rsp_fire) begin
      pending_d = pending_q - ONE_P;
    end
  end

  // Next-state for the non-stalling read pipeline.
  always_comb begin
    pipe_vld_d[0]  = rd_fire;
    pipe_data_d[0] = mem_q[line_idx];
    pipe_tag_d[0]  = mem_req_tag;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_data_d[i] = pipe_data_q[i-1];
      pipe_tag_d[i]  = pipe_tag_q[i-1];
    end
  end

  // Next-state for FIFO pointers and occupancy.
  always_comb begin
    wr_ptr_d   = fifo_enq ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = fifo_deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (fifo_enq && !fifo_deq) begin
      fifo_cnt_d = fifo_cnt_q + ONE_P;
    end else if (!fifo_enq && fifo_deq) begin
      fifo_cnt_d = fifo_cnt_q - ONE_P;
    end
  end

  // Control state: reset drops all in-flight reads and queued responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_vld_q[i] <= 1'b0;
      end
    end else begin
      pending_q  <= pending_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_d[i];
      end
    end
  end

  // Datapath registers carry no reset; their valids qualify them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LATENCY; i++) begin
      pipe_data_q[i] <= pipe_data_d[i];
      pipe_tag_q[i]  <= pipe_tag_d[i];
    end
    if (fifo_enq) begin
      fifo_data_q[wr_ptr_q] <= pipe_data_q[LATENCY-1];
      fifo_tag_q[wr_ptr_q]  <= pipe_tag_q[LATENCY-1];
    end
  end

  // The credit counter bounds occupancy, so a store into a full FIFO
  // (with or without a simultaneous dequeue) indicates broken accounting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(fifo_enq && fifo_full));
    end
  end

endmodule

// File: tb/tb_vx_mem_responder.sv
// Directed bench for vx_mem_responder with default parameters
// (16-byte lines, 8-bit tags, 256 lines, LATENCY=2, 4-entry queue).
module tb_vx_mem_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_req_valid;
  logic         mem_req_rw;
  logic [31:0]  mem_req_addr;
  logic [15:0]  mem_req_byteen;
  logic [127:0] mem_req_data;
  logic [7:0]   mem_req_tag;
  logic         mem_req_ready;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_data;
  logic [7:0]   mem_rsp_tag;
  logic         mem_rsp_ready;

  int checks = 0;
  int errors = 0;

  vx_mem_responder dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_byteen (mem_req_byteen),
    .mem_req_data   (mem_req_data),
    .mem_req_tag    (mem_req_tag),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_tag    (mem_rsp_tag),
    .mem_rsp_ready  (mem_rsp_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rw;
    logic [31:0]  addr;
    logic [15:0]  be;
    logic [127:0] data;
    logic [7:0]   tag;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request presented for exactly one edge.
  task automatic do_req(input logic rw, input logic [31:0] addr, input logic [15:0] be,
                        input logic [127:0] data, input logic [7:0] tag);
    mem_req_valid  = 1'b1;
    mem_req_rw     = rw;
    mem_req_addr   = addr;
    mem_req_byteen = be;
    mem_req_data   = data;
    mem_req_tag    = tag;
    #1;
    chk("req_ready_before_issue", 128'(mem_req_ready), 128'(1));
    step();
    mem_req_valid = 1'b0;
  endtask

  // Called in the cycle after a read fired with rsp_ready high and an empty queue.
  task automatic check_read(input string name, input logic [127:0] exp_data, input logic [7:0] exp_tag);
    chk({name, "_not_early"}, 128'(mem_rsp_valid), 128'(0));
    step();
    chk({name, "_valid"}, 128'(mem_rsp_valid), 128'(1));
    chk({name, "_data"},  mem_rsp_data, exp_data);
    chk({name, "_tag"},   128'(mem_rsp_tag), 128'(exp_tag));
    step();
    chk({name, "_consumed"}, 128'(mem_rsp_valid), 128'(0));
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h5,    16'hFFFF, {16{8'hAA}}, 8'h00, '0};
    tbl[1]  = '{1'b0, 32'h5,    16'h0000, '0,          8'h3C, {16{8'hAA}}};
    tbl[2]  = '{1'b1, 32'h7,    16'hFFFF, {16{8'h11}}, 8'h00, '0};
    tbl[3]  = '{1'b1, 32'h7,    16'h0001, {{15{8'h33}}, 8'h22}, 8'h00, '0};
    tbl[4]  = '{1'b0, 32'h7,    16'hFFFF, {16{8'hEE}}, 8'h01, {{15{8'h11}}, 8'h22}};
    tbl[5]  = '{1'b0, 32'h1005, 16'h0000, '0,          8'h02, {16{8'hAA}}};
    tbl[6]  = '{1'b0, 32'h9,    16'h0000, '0,          8'h03, '0};
    tbl[7]  = '{1'b1, 32'h9,    16'h8000, {16{8'hFF}}, 8'h00, '0};
    tbl[8]  = '{1'b0, 32'h9,    16'h0000, '0,          8'h04, {8'hFF, 120'h0}};
    tbl[9]  = '{1'b1, 32'h109,  16'h00F0, {16{8'h5A}}, 8'h00, '0};
    tbl[10] = '{1'b0, 32'h9,    16'h0000, '0,          8'h05, 128'hFF000000_00000000_5A5A5A5A_00000000};

    reset          = 1'b1;
    mem_req_valid  = 1'b0;
    mem_req_rw     = 1'b0;
    mem_req_addr   = '0;
    mem_req_byteen = '0;
    mem_req_data   = '0;
    mem_req_tag    = '0;
    mem_rsp_ready  = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("reset_rsp_valid", 128'(mem_rsp_valid), 128'(0));
    chk("reset_req_ready", 128'(mem_req_ready), 128'(1));

    // Table: each read directly follows the preceding write when one exists.
    for (int i = 0; i < 11; i++) begin
      do_req(tbl[i].rw, tbl[i].addr, tbl[i].be, tbl[i].data, tbl[i].tag);
      if (!tbl[i].rw) begin
        check_read($sformatf("vec%0d", i), tbl[i].exp, tbl[i].tag);
      end
    end

    // Back-pressure: six reads against a four-entry credit limit.
    mem_rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mem_req_valid  = 1'b1;
      mem_req_rw     = 1'b0;
      mem_req_addr   = 32'(i);
      mem_req_tag    = 8'(i);
      #1;
      chk($sformatf("bp_ready%0d", i), 128'(mem_req_ready), 128'(i < 4));
      step();
    end
    mem_req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("bp_stall_valid", 128'(mem_rsp_valid), 128'(1));
      chk("bp_stall_tag",   128'(mem_rsp_tag), 128'(0));
      chk("bp_stall_data",  mem_rsp_data, 128'(0));
      chk("bp_stall_ready", 128'(mem_req_ready), 128'(0));
      step();
    end
    mem_rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_drain_valid%0d", k), 128'(mem_rsp_valid), 128'(1));
      chk($sformatf("bp_drain_tag%0d", k),   128'(mem_rsp_tag), 128'(k));
      step();
    end
    chk("bp_drained", 128'(mem_rsp_valid), 128'(0));
    do_req(1'b0, 32'h4, '0, '0, 8'h04);
    check_read("bp_retry4", 128'(0), 8'h04);
    do_req(1'b0, 32'h5, '0, '0, 8'h05);
    check_read("bp_retry5", {16{8'hAA}}, 8'h05);

    // Sustained back-to-back reads with the consumer always ready.
    for (int c = 0; c < 11; c++) begin
      mem_req_valid = (c < 8);
      mem_req_rw    = 1'b0;
      mem_req_addr  = 32'h5;
      mem_req_tag   = 8'(10 + c);
      #1;
      chk($sformatf("stream_ready%0d", c), 128'(mem_req_ready), 128'(1));
      if (c >= 2 && c < 10) begin
        chk($sformatf("stream_valid%0d", c), 128'(mem_rsp_valid), 128'(1));
        chk($sformatf("stream_tag%0d", c),   128'(mem_rsp_tag), 128'(10 + c - 2));
        chk($sformatf("stream_data%0d", c),  mem_rsp_data, {16{8'hAA}});
      end else begin
        chk($sformatf("stream_idle%0d", c), 128'(mem_rsp_valid), 128'(0));
      end
      step();
    end
    mem_req_valid = 1'b0;

    // Reset mid-flight: three reads stalled, then reset with a write offered.
    mem_rsp_ready = 1'b0;
    do_req(1'b0, 32'h5, '0, '0, 8'h20);
    do_req(1'b0, 32'h5, '0, '0, 8'h21);
    do_req(1'b0, 32'h5, '0, '0, 8'h22);
    reset          = 1'b1;
    mem_req_valid  = 1'b1;
    mem_req_rw     = 1'b1;
    mem_req_addr   = 32'h5;
    mem_req_byteen = 16'hFFFF;
    mem_req_data   = '0;
    step();
    reset         = 1'b0;
    mem_req_valid = 1'b0;
    mem_rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_no_rsp%0d", k), 128'(mem_rsp_valid), 128'(0));
      chk($sformatf("rst_ready%0d", k),  128'(mem_req_ready), 128'(1));
      step();
    end
    do_req(1'b0, 32'h5, '0, '0, 8'h77);
    check_read("post_reset", {16{8'hAA}}, 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_mem_responder.md
VX_MEM_RESPONDER -- requirements
Module: VX_mem_responder

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 32: memory request address width, in line units.
REQ-002 SHALL have parameter MEM_DATA_SIZE, default 16: line size in bytes; MEM_DATA_WIDTH = MEM_DATA_SIZE*8.
REQ-003 SHALL have parameter MEM_TAG_WIDTH, default 8: request/response tag width.
REQ-004 SHALL have parameter NUM_LINES, default 256: backing-store depth, power of 2, >=2; LINE_SEL = log2(NUM_LINES), LINE_SEL <= MEM_ADDR_WIDTH.
REQ-005 SHALL have parameter LATENCY, default 2: read latency in cycles, >=1.
REQ-006 SHALL have parameter RSP_QUEUE_SIZE, default 4: response buffer depth, >=1.
REQ-007 SHALL have ports: clk in 1 (sole clock); reset in 1 (synchronous, active-high).
REQ-008 SHALL have ports: mem_req_valid in 1; mem_req_rw in 1 (1=write); mem_req_addr in MEM_ADDR_WIDTH; mem_req_byteen in MEM_DATA_SIZE; mem_req_data in MEM_DATA_WIDTH; mem_req_tag in MEM_TAG_WIDTH; mem_req_ready out 1.
REQ-009 SHALL have ports: mem_rsp_valid out 1; mem_rsp_data out MEM_DATA_WIDTH; mem_rsp_tag out MEM_TAG_WIDTH; mem_rsp_ready in 1.

Function
REQ-010 SHALL accept a request on a rising edge where mem_req_valid && mem_req_ready ("req fire").
REQ-011 SHALL index the store with mem_req_addr[LINE_SEL-1:0]; upper address bits ignored.
REQ-012 SHALL on write fire update only the bytes whose byteen bit is 1, leaving other bytes unchanged; writes produce no response.
REQ-013 SHALL on read fire capture line data and tag and deliver them as a response; byteen and data ignored for reads.
REQ-014 SHALL keep a pending counter (width log2(RSP_QUEUE_SIZE)+1): +1 on read fire, -1 on rsp fire, unchanged when both occur in the same cycle.
REQ-015 SHALL drive mem_req_ready = (pending < RSP_QUEUE_SIZE), independent of mem_req_rw and mem_req_valid; writes are accepted whenever ready is high.
REQ-016 SHALL present a read accepted at edge t on mem_rsp_valid no earlier than edge t+LATENCY-1 (visible in cycle t+LATENCY) when the response queue is empty and mem_rsp_ready is high; exactly that cycle under those conditions.
REQ-017 SHALL pipeline reads through a LATENCY-stage valid/data/tag pipeline that never stalls, feeding a FIFO of RSP_QUEUE_SIZE entries; the credit rule of REQ-015 SHALL guarantee the FIFO never overflows.
REQ-018 SHALL return responses in acceptance order.
REQ-019 SHALL return, for a read, the line contents including every write fired at an earlier edge (read fired at edge t+1 after a write at edge t to the same line returns the new data).
REQ-020 SHALL hold mem_rsp_valid, data and tag stable while mem_rsp_valid && !mem_rsp_ready.
REQ-021 SHALL fire a response on an edge with mem_rsp_valid && mem_rsp_ready; the FIFO head advances on that edge.
REQ-022 SHALL, when the FIFO holds zero entries and a pipeline output arrives in the same cycle as no dequeue, enqueue it; simultaneous enqueue and dequeue when full is impossible by REQ-015, and SHALL be flagged by a simulation assertion.
REQ-023 SHALL have store contents initialized to zero at time 0 and not altered by reset.

Reset
REQ-024 SHALL, while reset is high at an edge, clear pending counter, pipeline valids and FIFO pointers; next cycle mem_rsp_valid=0 and mem_req_ready=1.
REQ-025 SHALL discard in-flight reads on reset mid-operation; no stale response appears after reset deasserts.
REQ-026 SHALL ignore request inputs on edges where reset is high (no write performed).

Verification
REQ-027 Write addr 0x5, byteen 0xFFFF, data all 0xAA; next cycle read addr 0x5 tag 0x3C -> response in cycle t+2 (LATENCY=2), data all 0xAA, tag 0x3C.
REQ-028 Write addr 0x7 data 0x11.., then write addr 0x7 byteen 0x0001 data 0x..22; read -> byte0 = 0x22, bytes1-15 = 0x11.
REQ-029 mem_rsp_ready=0, issue 6 back-to-back reads tags 0..5 (RSP_QUEUE_SIZE=4) -> exactly 4 accepted, mem_req_ready=0 after 4th; raise rsp_ready -> tags 0,1,2,3 in order, then remaining reads accepted.
REQ-030 Sustained reads with mem_rsp_ready=1 -> one response per cycle, pending stays <=LATENCY, mem_req_ready never drops.
REQ-031 Issue 3 reads, assert reset for 1 cycle at edge t+1 -> mem_rsp_valid=0 from t+2 onward, no responses for tags issued; subsequent read returns correct data.
REQ-032 Read with upper address bits set (addr 0x1005, NUM_LINES=256) -> returns line 0x05 contents.
